fetch_unit: RTL and testbench

Instruction-fetch front end for the dual-issue Cortex-M0 core. Each cycle it drives the split even/odd program ROM address, bank-select and swap controls, and captures the returned halfword pair into a registered two-slot fetch buffer for decode. It advances by the number of instructions decode consumes, applies branch redirects, and recognises 32-bit Thumb prefixes and BKPT halts.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_predecode.sv | 34 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end and decode: FSM states,
// BKPT opcode, 32-bit Thumb prefix patterns and classification helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [7:0] BKPT_OP = 8'hBE;

  localparam logic [4:0] WIDE_PFX [3] = '{5'b11101, 5'b11110, 5'b11111};

  function automatic logic is_wide(input logic [15:0] hw);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (hw[15:11] == WIDE_PFX[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_bkpt(input logic [15:0] hw);
    return (hw[15:8] == BKPT_OP);
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational classification of a raw halfword pair: slot validity,
// 32-bit (wide) pairing and per-slot BKPT flags.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [15:0] i_ir_0,
  input  logic [15:0] i_ir_1,
  output logic [1:0]  o_valid,
  output logic        o_wide,
  output logic [1:0]  o_bkpt
);

  logic w_wide_0;
  logic w_wide_1;

  assign w_wide_0 = is_wide(i_ir_0);
  assign w_wide_1 = is_wide(i_ir_1);

  always_comb begin
    o_wide  = 1'b0;
    o_valid = 2'b11;
    if (w_wide_0) begin
      o_wide = 1'b1;
    end else if (w_wide_1) begin
      // a lone prefix in slot 1 waits until its suffix is fetched with it
      o_valid = 2'b01;
    end
  end

  // slot 1 of a wide pair is a suffix, never an instruction of its own
  assign o_bkpt[0] = is_bkpt(i_ir_0);
  assign o_bkpt[1] = is_bkpt(i_ir_1) & ~w_wide_0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the split even/odd ROM address, holds a
// registered two-slot fetch buffer, advances by consumed count, halts on BKPT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        consume,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W:0]   br_target,
  input  logic [15:0]       IR_0_in,
  input  logic [15:0]       IR_1_in,
  output logic [ADDR_W-1:0] Rom_addr,
  output logic              pc_1,
  output logic              sel_mem_1,
  output logic [1:0]        sel_mem_0,
  output logic [15:0]       fetch_IR_0,
  output logic [15:0]       fetch_IR_1,
  output logic [1:0]        fetch_valid,
  output logic              fetch_wide,
  output logic [ADDR_W:0]   fetch_pc,
  output logic              halted,
  output logic [31:0]       retire_count,
  output logic [1:0]        o_dbg_state
);

  localparam int PC_W = ADDR_W + 1;

  // Handshake: there is no valid/ready pair here. fetch_valid qualifies the
  // buffered slots; decode acknowledges by returning consume (slots taken) in
  // the same cycle, which only counts when stall and br_valid are both low.

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [PC_W-1:0] r_fetch_pc;
  logic [15:0]     r_ir_0;
  logic [15:0]     r_ir_1;
  logic [1:0]      r_valid;
  logic            r_wide;
  logic [1:0]      r_bkpt;
  logic            r_halted;
  logic [31:0]     r_retire;

  logic [1:0]      w_cons;
  logic [1:0]      w_nvalid;
  logic [1:0]      w_eff;
  logic [PC_W-1:0] w_a_pc;
  logic            w_consume_ok;
  logic            w_hit_bkpt;
  logic            w_load;
  logic [1:0]      w_pd_valid;
  logic            w_pd_wide;
  logic [1:0]      w_pd_bkpt;

  fetch_predecode u_predecode (
    .i_ir_0  (IR_0_in),
    .i_ir_1  (IR_1_in),
    .o_valid (w_pd_valid),
    .o_wide  (w_pd_wide),
    .o_bkpt  (w_pd_bkpt)
  );

  always_comb begin
    w_cons   = (consume == 2'd3) ? 2'd2 : consume;
    w_nvalid = (r_valid == 2'b11) ? 2'd2 : (r_valid == 2'b01) ? 2'd1 : 2'd0;
    w_eff    = (w_cons < w_nvalid) ? w_cons : w_nvalid;
    // half of a 32-bit instruction cannot be taken
    if (r_wide && (w_eff == 2'd1)) w_eff = 2'd0;
  end

  assign w_consume_ok = (r_state == ST_RUN) && !br_valid && !stall;
  assign w_hit_bkpt   = w_consume_ok &&
                        (((w_eff != 2'd0) && r_bkpt[0]) ||
                         ((w_eff == 2'd2) && r_bkpt[1]));

  always_comb begin
    w_a_pc       = r_fetch_pc;
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_next_state = ST_RUN;
        w_load       = 1'b1;
      end
      ST_RUN: begin
        if (br_valid)   w_a_pc = br_target;
        else if (!stall) w_a_pc = r_fetch_pc + PC_W'(w_eff);
        if (w_hit_bkpt) w_next_state = ST_HALT;
        else            w_load = br_valid || !stall;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_fetch_pc <= PC_W'(RESET_PC);
      r_ir_0     <= 16'h0000;
      r_ir_1     <= 16'h0000;
      r_valid    <= 2'b00;
      r_wide     <= 1'b0;
      r_bkpt     <= 2'b00;
      r_halted   <= 1'b0;
      r_retire   <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_fetch_pc <= w_a_pc;
        r_ir_0     <= IR_0_in;
        r_ir_1     <= IR_1_in;
        r_valid    <= w_pd_valid;
        r_wide     <= w_pd_wide;
        r_bkpt     <= w_pd_bkpt;
      end
      if (w_consume_ok) r_retire <= r_retire + {30'd0, w_eff};
      if (w_hit_bkpt) begin
        r_halted <= 1'b1;
        r_valid  <= 2'b00;
      end
    end
  end

  assign Rom_addr     = w_a_pc[ADDR_W:1];
  assign pc_1         = w_a_pc[0];
  assign sel_mem_1    = ~w_a_pc[0];
  assign sel_mem_0    = w_a_pc[0] ? 2'd2 : 2'd0;
  assign fetch_IR_0   = r_ir_0;
  assign fetch_IR_1   = r_ir_1;
  assign fetch_valid  = r_valid;
  assign fetch_wide   = r_wide;
  assign fetch_pc     = r_fetch_pc;
  assign halted       = r_halted;
  assign retire_count = r_retire;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: combinational ROM models drive two instances
// (default width, and ADDR_W=2 for wrap), results checked against hand values.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rst_b;
  logic [1:0]  consume;
  logic        stall;
  logic        br_valid;
  logic [14:0] br_target;

  logic [15:0] rom [0:32767];
  logic [15:0] rom_b [0:7];

  // main instance, ADDR_W=14
  logic [15:0] IR_0_in, IR_1_in;
  logic [13:0] Rom_addr;
  logic        pc_1, sel_mem_1;
  logic [1:0]  sel_mem_0;
  logic [15:0] fetch_IR_0, fetch_IR_1;
  logic [1:0]  fetch_valid;
  logic        fetch_wide;
  logic [14:0] fetch_pc;
  logic        halted;
  logic [31:0] retire_count;
  logic [1:0]  dbg_state;
  logic [14:0] w_apc;

  // wrap instance, ADDR_W=2, RESET_PC=7
  logic [15:0] b_ir_0_in, b_ir_1_in;
  logic [1:0]  b_rom_addr;
  logic        b_pc_1, b_sel_mem_1;
  logic [1:0]  b_sel_mem_0;
  logic [15:0] b_fetch_ir_0, b_fetch_ir_1;
  logic [1:0]  b_fetch_valid;
  logic        b_fetch_wide;
  logic [2:0]  b_fetch_pc;
  logic        b_halted;
  logic [31:0] b_retire_count;
  logic [1:0]  b_dbg_state;
  logic [2:0]  b_apc;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  assign w_apc   = {Rom_addr, pc_1};
  assign IR_0_in = rom[w_apc];
  assign IR_1_in = rom[w_apc + 15'd1];

  assign b_apc     = {b_rom_addr, b_pc_1};
  assign b_ir_0_in = rom_b[b_apc];
  assign b_ir_1_in = rom_b[b_apc + 3'd1];

  fetch_unit #(.ADDR_W(14), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .consume(consume), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .IR_0_in(IR_0_in), .IR_1_in(IR_1_in),
    .Rom_addr(Rom_addr), .pc_1(pc_1), .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
    .fetch_IR_0(fetch_IR_0), .fetch_IR_1(fetch_IR_1), .fetch_valid(fetch_valid),
    .fetch_wide(fetch_wide), .fetch_pc(fetch_pc), .halted(halted),
    .retire_count(retire_count), .o_dbg_state(dbg_state)
  );

  fetch_unit #(.ADDR_W(2), .RESET_PC(7)) dut_b (
    .clk(clk), .rst(rst_b), .consume(consume), .stall(stall),
    .br_valid(br_valid), .br_target(br_target[2:0]),
    .IR_0_in(b_ir_0_in), .IR_1_in(b_ir_1_in),
    .Rom_addr(b_rom_addr), .pc_1(b_pc_1), .sel_mem_1(b_sel_mem_1), .sel_mem_0(b_sel_mem_0),
    .fetch_IR_0(b_fetch_ir_0), .fetch_IR_1(b_fetch_ir_1), .fetch_valid(b_fetch_valid),
    .fetch_wide(b_fetch_wide), .fetch_pc(b_fetch_pc), .halted(b_halted),
    .retire_count(b_retire_count), .o_dbg_state(b_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2101; rom[1] = 16'h220C; rom[2] = 16'h23FF; rom[3] = 16'hB24C;
    rom[4] = 16'hB25C; rom[5] = 16'hB2DC; rom[6] = 16'hB21D;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    br_valid = 1'b0;
    stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    rst_b = 1'b1;
    consume = 2'd2;
    stall = 1'b0;
    br_valid = 1'b0;
    br_target = '0;
    load_default();
    for (int i = 0; i < 8; i++) rom_b[i] = 16'h1000 + 16'(i);
    #1;

    // reset state
    check("rst_pc", fetch_pc, 0);
    check("rst_valid", fetch_valid, 0);
    check("rst_wide", fetch_wide, 0);
    check("rst_ir0", fetch_IR_0, 0);
    check("rst_halted", halted, 0);
    check("rst_retire", retire_count, 0);
    check("rst_state", dbg_state, 0);
    check("rst_sel", {Rom_addr, pc_1, sel_mem_1, sel_mem_0}, {14'd0, 1'b0, 1'b1, 2'd0});
    check("rst_b_addr", {b_rom_addr, b_pc_1, b_sel_mem_1, b_sel_mem_0}, {2'd3, 1'b1, 1'b0, 2'd2});

    // 1: streaming with consume=2
    exp_q.push_back({16'h2101, 16'h220C});
    exp_q.push_back({16'h23FF, 16'hB24C});
    exp_q.push_back({16'hB25C, 16'hB2DC});
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t1_pair", {fetch_IR_0, fetch_IR_1}, exp_q.pop_front());
      check("t1_pc", fetch_pc, 2 * c);
      check("t1_valid", fetch_valid, 2'b11);
      check("t1_retire", retire_count, 2 * c);
      if (c == 0) check("t1_sel", {sel_mem_1, sel_mem_0}, {1'b1, 2'd0});
    end

    // 2: consume=1 from pc 0
    consume = 2'd1;
    apply_reset();
    step();
    check("t2_addr", {Rom_addr, pc_1, sel_mem_0, sel_mem_1}, {14'd0, 1'b1, 2'd2, 1'b0});
    step();
    check("t2_pair", {fetch_IR_0, fetch_IR_1}, {16'h220C, 16'h23FF});
    check("t2_pc", fetch_pc, 1);
    check("t2_retire", retire_count, 1);

    // 3: redirect wins over stall, no retire
    br_valid = 1'b1; br_target = 15'd5; stall = 1'b1; consume = 2'd2;
    step();
    check("t3_pair", {fetch_IR_0, fetch_IR_1}, {16'hB2DC, 16'hB21D});
    check("t3_pc", fetch_pc, 5);
    check("t3_retire", retire_count, 1);
    br_valid = 1'b0;
    step();
    check("t3_stall_pc", fetch_pc, 5);
    check("t3_stall_ret", retire_count, 1);
    stall = 1'b0;

    // 4: wide pair at pc 0
    rom[0] = 16'hF000; rom[1] = 16'hF800;
    consume = 2'd1;
    apply_reset();
    step();
    check("t4_wide", {fetch_wide, fetch_valid}, {1'b1, 2'b11});
    step();
    check("t4_c1_pc", fetch_pc, 0);
    check("t4_c1_retire", retire_count, 0);
    consume = 2'd2;
    step();
    check("t4_c2_pc", fetch_pc, 2);
    check("t4_c2_retire", retire_count, 2);
    check("t4_c2_pair", {fetch_IR_0, fetch_IR_1, 2'b00, fetch_wide}, {16'h23FF, 16'hB24C, 3'b000});
    // variant: lone prefix in slot 1
    rom[0] = 16'h2101; rom[1] = 16'hF000;
    consume = 2'd0;
    apply_reset();
    step();
    check("t4v_valid", {fetch_wide, fetch_valid}, {1'b0, 2'b01});
    consume = 2'd2;
    step();
    check("t4v_pc", fetch_pc, 1);
    check("t4v_retire", retire_count, 1);
    check("t4v_wide", {fetch_wide, fetch_valid}, {1'b1, 2'b11});

    // 5: BKPT at pc 3
    load_default();
    rom[3] = 16'hBE00;
    consume = 2'd2;
    apply_reset();
    step();
    step();
    check("t5_pc2", fetch_pc, 2);
    consume = 2'd1;
    step();
    check("t5_pc3", fetch_pc, 3);
    check("t5_not_halted", halted, 0);
    step();
    check("t5_halted", halted, 1);
    check("t5_valid", fetch_valid, 2'b00);
    check("t5_pc_frozen", fetch_pc, 3);
    check("t5_state", dbg_state, 2);
    br_valid = 1'b1; br_target = 15'd5; consume = 2'd2;
    step();
    check("t5_br_ign_pc", fetch_pc, 3);
    check("t5_br_ign_h", halted, 1);
    check("t5_br_ign_addr", {Rom_addr, pc_1}, {14'd1, 1'b1});
    br_valid = 1'b0;

    // 6: wrap on narrow instance, then asynchronous reset
    consume = 2'd2;
    rst_b = 1'b0;
    step();
    check("t6_pc7", b_fetch_pc, 7);
    check("t6_pair7", {b_fetch_ir_0, b_fetch_ir_1}, {16'h1007, 16'h1000});
    step();
    check("t6_wrap_pc", b_fetch_pc, 1);
    check("t6_wrap_pair", {b_fetch_ir_0, b_fetch_ir_1}, {16'h1001, 16'h1002});
    check("t6_retire", b_retire_count, 2);
    #3;
    rst_b = 1'b1;
    #1;
    check("t6_async_pc", b_fetch_pc, 7);
    check("t6_async_valid", b_fetch_valid, 0);
    check("t6_async_ir", {b_fetch_ir_0, b_fetch_ir_1}, 0);
    check("t6_async_retire", b_retire_count, 0);
    check("t6_async_state", b_dbg_state, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
